// File: rtl/bpm_update_scheduler_pkg.sv
// Shared definitions for the BPM update scheduler: FSM states, button step sizes
// and the clocks-per-minute dividend used for period conversion.
package bpm_update_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_OFFER  = 2'd2
  } state_e;

  localparam int unsigned STEP_SMALL         = 1;
  localparam int unsigned STEP_LARGE         = 5;
  localparam int unsigned SECONDS_PER_MINUTE = 60;

  function automatic logic [63:0] period_dividend(input int unsigned clk_hz);
    return 64'(clk_hz) * 64'(SECONDS_PER_MINUTE);
  endfunction

endpackage

// File: rtl/bpm_update_scheduler_divider.sv
// Start/done restoring divider: one quotient bit per cycle, PERIOD_W cycles per
// division. A start while a division is running is ignored.
module bpm_period_divider #(
  parameter int unsigned PERIOD_W = 34,
  parameter int unsigned BPM_W    = 9
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic [PERIOD_W-1:0] i_dividend,
  input  logic [BPM_W-1:0]    i_divisor,
  output logic                o_done,
  output logic [PERIOD_W-1:0] o_quotient
);

  localparam int unsigned CNT_W = $clog2(PERIOD_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_W - 1);

  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PERIOD_W-1:0] quo_q, quo_d;
  logic [BPM_W-1:0]    rem_q, rem_d;
  logic [BPM_W-1:0]    dvs_q;
  logic [BPM_W:0]      trial;

  // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    trial = {rem_q, quo_q[PERIOD_W-1]};
    if (trial >= {1'b0, dvs_q}) begin
      rem_d = BPM_W'(trial - {1'b0, dvs_q});
      quo_d = {quo_q[PERIOD_W-2:0], 1'b1};
    end else begin
      rem_d = trial[BPM_W-1:0];
      quo_d = {quo_q[PERIOD_W-2:0], 1'b0};
    end
  end

  // Done is flagged during the final step so the caller can capture quo_d on the same edge
  assign o_done     = busy_q && (cnt_q == LAST);
  assign o_quotient = quo_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (!busy_q) begin
      if (i_start) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
        quo_q  <= i_dividend;
        rem_q  <= '0;
        dvs_q  <= i_divisor;
      end
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bpm_update_scheduler.sv
// Owns the committed BPM, accumulates button/UART tempo requests, clamps them, and
// offers the matching beat period to the beat generator over valid/ready.
module bpm_update_scheduler
  import bpm_update_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BPM_W       = 9,
  parameter int unsigned BPM_MIN     = 30,
  parameter int unsigned BPM_MAX     = 300,
  parameter int unsigned BPM_DEFAULT = 120,
  parameter int unsigned PERIOD_W    = 34
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_btn_plus_1,
  input  logic                i_btn_plus_5,
  input  logic                i_btn_minus_1,
  input  logic                i_btn_minus_5,
  input  logic                i_uart_msg,
  input  logic [31:0]         i_uart_bpm_count,
  output logic [BPM_W-1:0]    o_bpm,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_period_valid,
  input  logic                i_period_ready,
  output logic                o_bpm_changed,
  output logic                o_busy
);

  localparam int unsigned DW = BPM_W + 2;
  localparam int unsigned SW = 34;

  localparam logic [PERIOD_W-1:0] DIVIDEND       = PERIOD_W'(period_dividend(CLK_HZ));
  localparam logic [PERIOD_W-1:0] PERIOD_DEFAULT =
    PERIOD_W'(period_dividend(CLK_HZ) / 64'(BPM_DEFAULT));

  localparam logic signed [DW:0]    SAT_HI = (DW+1)'(BPM_MAX);
  localparam logic signed [DW:0]    SAT_LO = -SAT_HI;
  localparam logic signed [DW:0]    STEP_S = (DW+1)'(STEP_SMALL);
  localparam logic signed [DW:0]    STEP_L = (DW+1)'(STEP_LARGE);
  localparam logic signed [SW-1:0]  MIN_S  = SW'(BPM_MIN);
  localparam logic signed [SW-1:0]  MAX_S  = SW'(BPM_MAX);

  state_e                state_q;
  logic [BPM_W-1:0]      bpm_q, target_q;
  logic [PERIOD_W-1:0]   period_q;
  logic                  valid_q, changed_q;

  logic                  uart_pend_q, uart_pend_d;
  logic [31:0]           uart_val_q, uart_val_d;
  logic signed [DW-1:0]  delta_q, delta_d;
  logic signed [DW:0]    step_sum, delta_sum;

  logic                  take_pend, div_start, div_done;
  logic signed [SW-1:0]  raw_sum;
  logic [BPM_W-1:0]      target_c;
  logic [PERIOD_W-1:0]   div_quotient;

  assign take_pend = (state_q == S_IDLE) && (uart_pend_q || (delta_q != '0));

  always_comb begin
    raw_sum = uart_pend_q ? $signed({2'b00, uart_val_q})
                          : $signed({{(SW-BPM_W){1'b0}}, bpm_q});
    raw_sum = raw_sum + $signed({{(SW-DW){delta_q[DW-1]}}, delta_q});
    if (raw_sum < MIN_S)      target_c = BPM_W'(BPM_MIN);
    else if (raw_sum > MAX_S) target_c = BPM_W'(BPM_MAX);
    else                      target_c = raw_sum[BPM_W-1:0];
  end

  assign div_start = take_pend && (target_c != bpm_q);

  // Slot is consumed by IDLE first, then this cycle's UART/button pulses land in it
  always_comb begin
    step_sum = '0;
    if (i_btn_plus_1)  step_sum = step_sum + STEP_S;
    if (i_btn_plus_5)  step_sum = step_sum + STEP_L;
    if (i_btn_minus_1) step_sum = step_sum - STEP_S;
    if (i_btn_minus_5) step_sum = step_sum - STEP_L;

    uart_pend_d = take_pend ? 1'b0 : uart_pend_q;
    uart_val_d  = uart_val_q;
    delta_sum   = take_pend ? '0 : {delta_q[DW-1], delta_q};
    if (i_uart_msg) begin
      uart_pend_d = 1'b1;
      uart_val_d  = i_uart_bpm_count;
      delta_sum   = '0;
    end
    delta_sum = delta_sum + step_sum;

    if (delta_sum > SAT_HI)      delta_d = SAT_HI[DW-1:0];
    else if (delta_sum < SAT_LO) delta_d = SAT_LO[DW-1:0];
    else                         delta_d = delta_sum[DW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      uart_pend_q <= 1'b0;
      uart_val_q  <= '0;
      delta_q     <= '0;
    end else begin
      uart_pend_q <= uart_pend_d;
      uart_val_q  <= uart_val_d;
      delta_q     <= delta_d;
    end
  end

  bpm_period_divider #(
    .PERIOD_W (PERIOD_W),
    .BPM_W    (BPM_W)
  ) u_divider (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_start    (div_start),
    .i_dividend (DIVIDEND),
    .i_divisor  (target_c),
    .o_done     (div_done),
    .o_quotient (div_quotient)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_OFFER;
      bpm_q     <= BPM_W'(BPM_DEFAULT);
      target_q  <= BPM_W'(BPM_DEFAULT);
      period_q  <= PERIOD_DEFAULT;
      valid_q   <= 1'b1;
      changed_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            target_q <= target_c;
            state_q  <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (div_done) begin
            period_q <= div_quotient;
            valid_q  <= 1'b1;
            state_q  <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (valid_q && i_period_ready) begin
            bpm_q     <= target_q;
            valid_q   <= 1'b0;
            changed_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_bpm          = bpm_q;
  assign o_period       = period_q;
  assign o_period_valid = valid_q;
  assign o_bpm_changed  = changed_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_bpm_update_scheduler.sv
// Self-checking bench for bpm_update_scheduler: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a cycle-level integer model.
module tb_bpm_update_scheduler;

  localparam int     PW       = 34;
  localparam longint DIVIDEND = 60000;

  logic          clk;
  logic          i_reset_n;
  logic          i_btn_plus_1, i_btn_plus_5, i_btn_minus_1, i_btn_minus_5;
  logic          i_uart_msg;
  logic [31:0]   i_uart_bpm_count;
  logic [8:0]    o_bpm;
  logic [PW-1:0] o_period;
  logic          o_period_valid;
  logic          i_period_ready;
  logic          o_bpm_changed;
  logic          o_busy;

  bpm_update_scheduler #(
    .CLK_HZ      (1000),
    .BPM_W       (9),
    .BPM_MIN     (30),
    .BPM_MAX     (300),
    .BPM_DEFAULT (120),
    .PERIOD_W    (PW)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (i_reset_n),
    .i_btn_plus_1     (i_btn_plus_1),
    .i_btn_plus_5     (i_btn_plus_5),
    .i_btn_minus_1    (i_btn_minus_1),
    .i_btn_minus_5    (i_btn_minus_5),
    .i_uart_msg       (i_uart_msg),
    .i_uart_bpm_count (i_uart_bpm_count),
    .o_bpm            (o_bpm),
    .o_period         (o_period),
    .o_period_valid   (o_period_valid),
    .i_period_ready   (i_period_ready),
    .o_bpm_changed    (o_bpm_changed),
    .o_busy           (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: committed tempo, pending request, offer/divide progress
  int     m_bpm, m_target, m_div_left, m_delta;
  longint m_period, m_uval;
  bit     m_valid, m_changed, m_upend;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp_bpm(input longint v);
    if (v < 30)  return 30;
    if (v > 300) return 300;
    return int'(v);
  endfunction

  task automatic model_reset();
    m_bpm = 120; m_target = 120; m_period = DIVIDEND / 120;
    m_valid = 1; m_changed = 0; m_div_left = 0;
    m_upend = 0; m_uval = 0; m_delta = 0;
  endtask

  // Advance the model across one clock edge given this cycle's inputs
  task automatic model_step(input bit uart, input longint val, input bit [3:0] btn, input bit ready);
    bit take;
    int t;
    take = !m_valid && (m_div_left == 0) && (m_upend || m_delta != 0);
    m_changed = 0;
    if (m_valid) begin
      if (ready) begin
        m_bpm = m_target; m_valid = 0; m_changed = 1;
      end
    end else if (m_div_left > 0) begin
      m_div_left--;
      if (m_div_left == 0) begin
        m_valid = 1;
        m_period = DIVIDEND / m_target;
      end
    end else if (take) begin
      t = clamp_bpm((m_upend ? m_uval : longint'(m_bpm)) + m_delta);
      if (t != m_bpm) begin
        m_target = t;
        m_div_left = PW;
      end
    end
    if (take) begin m_upend = 0; m_delta = 0; end
    if (uart) begin m_upend = 1; m_uval = val; m_delta = 0; end
    m_delta += (btn[0] ? 1 : 0) + (btn[1] ? 5 : 0) - (btn[2] ? 1 : 0) - (btn[3] ? 5 : 0);
    if (m_delta > 300)  m_delta = 300;
    if (m_delta < -300) m_delta = -300;
  endtask

  // btn: [0]=+1 [1]=+5 [2]=-1 [3]=-5. Called at a negedge; returns at the next negedge.
  task automatic step(input bit uart, input logic [31:0] val, input bit [3:0] btn, input bit ready);
    i_uart_msg = uart;
    i_uart_bpm_count = val;
    {i_btn_minus_5, i_btn_minus_1, i_btn_plus_5, i_btn_plus_1} = btn;
    i_period_ready = ready;
    model_step(uart, longint'(val), btn, ready);
    @(posedge clk);
    @(negedge clk);
    i_uart_msg = 1'b0;
    {i_btn_minus_5, i_btn_minus_1, i_btn_plus_5, i_btn_plus_1} = 4'b0000;
    chk("model_bpm", o_bpm, m_bpm);
    chk("model_period", o_period, m_period);
    chk("model_valid", o_period_valid, m_valid);
    chk("model_changed", o_bpm_changed, m_changed);
    chk("model_busy", o_busy, (m_valid || m_div_left > 0) ? 1 : 0);
  endtask

  task automatic wait_valid(input bit ready, output int cycles);
    cycles = 0;
    while (!o_period_valid && cycles < 80) begin
      step(1'b0, 32'd0, 4'b0000, ready);
      cycles++;
    end
    chk("wait_valid_timeout", o_period_valid, 1);
  endtask

  // Asserts reset at a negedge, checks the asynchronous response, releases two cycles later
  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_bpm", o_bpm, 120);
    chk("rst_period", o_period, 500);
    chk("rst_valid", o_period_valid, 1);
    chk("rst_changed", o_bpm_changed, 0);
    chk("rst_busy", o_busy, 1);
    @(negedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  typedef struct {
    bit          uart;
    logic [31:0] val;
    bit [3:0]    btn;
    bit          offer;
    int          bpm;
    longint      period;
  } vec_t;

  vec_t tv[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    bit saw_busy, saw_valid, saw_changed;

    tv[0]  = '{1'b0, 32'd0,          4'b0010, 1'b1, 125, 480};
    tv[1]  = '{1'b1, 32'd0,          4'b0000, 1'b1, 30,  2000};
    tv[2]  = '{1'b0, 32'd0,          4'b1000, 1'b0, 30,  2000};
    tv[3]  = '{1'b1, 32'd1000,       4'b0000, 1'b1, 300, 200};
    tv[4]  = '{1'b0, 32'd0,          4'b0001, 1'b0, 300, 200};
    tv[5]  = '{1'b1, 32'd120,        4'b0100, 1'b1, 119, 504};
    tv[6]  = '{1'b0, 32'd0,          4'b0111, 1'b1, 124, 483};
    tv[7]  = '{1'b1, 32'd29,         4'b0000, 1'b1, 30,  2000};
    tv[8]  = '{1'b1, 32'd301,        4'b0000, 1'b1, 300, 200};
    tv[9]  = '{1'b0, 32'd0,          4'b1000, 1'b1, 295, 203};
    tv[10] = '{1'b1, 32'hFFFF_FFFF,  4'b0010, 1'b1, 300, 200};

    i_reset_n = 1'b1;
    i_uart_msg = 1'b0;
    i_uart_bpm_count = '0;
    {i_btn_minus_5, i_btn_minus_1, i_btn_plus_5, i_btn_plus_1} = 4'b0000;
    i_period_ready = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset release with ready high: default offer accepted on the first edge
    do_reset();
    step(1'b0, 32'd0, 4'b0000, 1'b1);
    chk("first_changed", o_bpm_changed, 1);
    chk("first_bpm", o_bpm, 120);
    chk("first_valid", o_period_valid, 0);

    for (int i = 0; i < 11; i++) begin
      step(tv[i].uart, tv[i].val, tv[i].btn, 1'b1);
      if (tv[i].offer) begin
        wait_valid(1'b1, cyc);
        chk($sformatf("vec%0d_latency", i), cyc + 1, 2 + PW);
        chk($sformatf("vec%0d_period", i), o_period, tv[i].period);
        step(1'b0, 32'd0, 4'b0000, 1'b1);
        chk($sformatf("vec%0d_bpm", i), o_bpm, tv[i].bpm);
        chk($sformatf("vec%0d_changed", i), o_bpm_changed, 1);
      end else begin
        saw_busy = 0; saw_valid = 0; saw_changed = 0;
        for (int k = 0; k < 45; k++) begin
          saw_busy    |= o_busy;
          saw_valid   |= o_period_valid;
          saw_changed |= o_bpm_changed;
          step(1'b0, 32'd0, 4'b0000, 1'b1);
        end
        chk($sformatf("vec%0d_no_busy", i), saw_busy, 0);
        chk($sformatf("vec%0d_no_offer", i), saw_valid, 0);
        chk($sformatf("vec%0d_no_changed", i), saw_changed, 0);
        chk($sformatf("vec%0d_bpm", i), o_bpm, tv[i].bpm);
        chk($sformatf("vec%0d_period", i), o_period, tv[i].period);
      end
    end

    // Requests arriving during DIVIDE are merged and applied after the commit
    do_reset();
    step(1'b0, 32'd0, 4'b0000, 1'b1);
    step(1'b0, 32'd0, 4'b0001, 1'b1);
    repeat (3) step(1'b0, 32'd0, 4'b0000, 1'b1);
    step(1'b0, 32'd0, 4'b0001, 1'b1);
    step(1'b0, 32'd0, 4'b0000, 1'b1);
    step(1'b0, 32'd0, 4'b0001, 1'b1);
    step(1'b0, 32'd0, 4'b0001, 1'b1);
    step(1'b0, 32'd0, 4'b1000, 1'b1);
    wait_valid(1'b1, cyc);
    chk("merge_first_period", o_period, 495);
    step(1'b0, 32'd0, 4'b0000, 1'b1);
    chk("merge_first_bpm", o_bpm, 121);
    wait_valid(1'b1, cyc);
    chk("merge_second_period", o_period, 504);
    step(1'b0, 32'd0, 4'b0000, 1'b1);
    chk("merge_second_bpm", o_bpm, 119);

    // Offer held while ready is low; UART+button in OFFER applied afterwards
    do_reset();
    step(1'b0, 32'd0, 4'b0000, 1'b1);
    step(1'b0, 32'd0, 4'b0001, 1'b0);
    wait_valid(1'b0, cyc);
    chk("hold_period_start", o_period, 495);
    step(1'b1, 32'd200, 4'b0001, 1'b0);
    for (int k = 0; k < 9; k++) begin
      chk("hold_valid", o_period_valid, 1);
      chk("hold_period", o_period, 495);
      chk("hold_bpm", o_bpm, 120);
      step(1'b0, 32'd0, 4'b0000, 1'b0);
    end
    step(1'b0, 32'd0, 4'b0000, 1'b1);
    chk("hold_commit_bpm", o_bpm, 121);
    chk("hold_commit_changed", o_bpm_changed, 1);
    wait_valid(1'b1, cyc);
    chk("hold_uart_period", o_period, 298);
    step(1'b0, 32'd0, 4'b0000, 1'b1);
    chk("hold_uart_bpm", o_bpm, 201);

    // Reset in the middle of a division aborts it and discards pending requests
    step(1'b0, 32'd0, 4'b0010, 1'b1);
    repeat (10) step(1'b0, 32'd0, 4'b0000, 1'b1);
    chk("abort_in_divide", o_busy, 1);
    step(1'b0, 32'd0, 4'b0001, 1'b1);
    do_reset();
    step(1'b0, 32'd0, 4'b0000, 1'b1);
    chk("abort_reoffer_changed", o_bpm_changed, 1);
    chk("abort_reoffer_bpm", o_bpm, 120);
    saw_valid = 0;
    for (int k = 0; k < 45; k++) begin
      step(1'b0, 32'd0, 4'b0000, 1'b1);
      saw_valid |= o_period_valid;
    end
    chk("abort_pending_empty", saw_valid, 0);
    chk("abort_final_bpm", o_bpm, 120);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit          u;
      logic [31:0] v;
      bit [3:0]    b;
      u = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 350)) : 32'($urandom());
      for (int j = 0; j < 4; j++) b[j] = ($urandom_range(0, 99) < 8);
      step(u, v, b, ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
